demux5bit_router: RTL and testbench
===================================

# demux5bit_router

- Buffered 1-to-4 demultiplexer: the inverse of the 5-bit 4-to-1 selection mux.
- Accepts one WIDTH-bit word per cycle from a single valid/ready source and steers it to the output channel chosen by `sel`.
- Each channel has its own DEPTH-entry FIFO, so a stalled consumer blocks only words addressed to it.
- It sits between a shared datapath producer and four independent consumers, and also counts the total words accepted.

## Interface
- WIDTH, 5, data width of every channel.
- DEPTH, 2, entries per channel FIFO; a power of two, ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  word to route.
- sel  input  2  destination channel: 0→ch1, 1→ch2, 2→ch3, 3→ch4.
- in_valid  input  1  data_in/sel are valid this cycle.
- in_ready  output  1  the selected channel can accept a word.
- data_out1..data_out4  output  WIDTH each  head entry of each channel FIFO.
- out_valid  output  4  bit i-1 set when channel i is non-empty.
- out_ready  input  4  bit i-1 set when consumer i takes its head this cycle.
- accept_count  output  8  total words accepted, wraps modulo 256.

## Operation
- Channel c has a circular buffer of DEPTH entries, a read pointer, a write pointer (log2(DEPTH) bits each) and an occupancy count cnt[c] (0..DEPTH).
- in_ready = (cnt[sel] != DEPTH).
  - in_ready depends only on sel and registered state.
  - There is no combinational path from out_ready to in_ready.
  - in_ready does not depend on in_valid.
- **Push** occurs when in_valid & in_ready. Channel sel then:
  - writes data_in at its write pointer;
  - increments the write pointer, wrapping modulo DEPTH.
- **Pop** of channel c occurs when out_valid[c] & out_ready[c]. The read pointer increments, wrapping modulo DEPTH.
- Count update per channel and cycle:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
  - neither: unchanged
- out_valid[c] = (cnt[c] != 0).
- data_out_c = entry at the read pointer, driven combinationally from the register array.
  - It is stable while out_valid is set and no pop occurs.
  - While empty, data_out_c shows the stale entry. It is a don't-care, but it must not be X after reset.
- Push to one channel and pops on any other channels occur in the same cycle independently. All four channels may pop in one cycle.
- accept_count increments by 1 on every push. 255 + 1 → 0.
- sel changing while in_valid is low has no effect. While in_valid is high and in_ready is low, the source may change sel; in_ready is re-evaluated for the new sel in that same cycle.

## Timing
- **Reset** (rst_n low, asynchronous, takes effect immediately, no clock needed):
  - all counts and pointers = 0
  - all storage = 0
  - out_valid = 4'b0000
  - accept_count = 0
  - data_out1..4 = 0
  - in_ready = 1
- Reset asserted mid-transfer discards all buffered words; nothing is replayed.
- Deassertion is treated as synchronous by the surrounding design. The first push is possible on the first rising edge with rst_n high.
- **Latency:** a word pushed at edge N appears on data_out_c with out_valid[c]=1 immediately after edge N (one cycle, registered).
- **Throughput:** one push per cycle, plus up to four pops per cycle.
- **Full channel:** cnt[c]=DEPTH forces in_ready=0 for sel=c, even if out_ready[c]=1 in the same cycle. After the pop, in_ready rises the following cycle.
- **Empty channel:** a push and out_ready in the same cycle does not pop the new word. It becomes poppable the next cycle.

## Test plan
- **Reset values:** assert rst_n=0 mid-cycle.
  - Outputs go to reset values without a clock edge: out_valid=0, in_ready=1, accept_count=0, data_out1..4=0.
- **Basic routing:** push 5'h11 with sel=0, 5'h12 with sel=1, 5'h13 with sel=2, 5'h14 with sel=3 on consecutive edges, out_ready=0.
  - Required: each data_out_c holds its value with out_valid=4'b1111.
  - Required: accept_count=4.
- **Fill, backpressure and wrap:** push 5'h0A and 5'h0B to ch2 with out_ready=0, then try 5'h0C.
  - in_ready=0; the 5'h0C push is not accepted; cnt stays 2.
  - Raise out_ready[1] for one cycle, then push 5'h0C: pops return 5'h0A, 5'h0B, 5'h0C in order, with the write pointer wrapping.
- **Head-of-line isolation:** fill ch1 (out_ready[0]=0), then push 5'h1F to ch4.
  - The ch4 push is accepted in one cycle: in_ready=1 for sel=3 while in_ready=0 for sel=0.
- **Simultaneous push/pop:** ch3 holds 1 word; push 5'h07 to ch3 while out_ready[2]=1.
  - cnt stays 1; the old head is popped; data_out3=5'h07 on the next cycle.
- **Counter wrap:** perform 257 pushes with all out_ready=1, sel cycling 0..3.
  - accept_count=1; no out_valid bit is stuck high after draining.

Source files
------------

// File: rtl/demux5bit_router.sv
// demux5bit_router: buffered 1-to-4 demultiplexer with one FIFO per channel.
// A single valid/ready source is steered by sel into one of four channel
// FIFOs; each channel drains independently, so a stalled consumer only blocks
// words addressed to it. A wrapping 8-bit counter tallies accepted words.
//
// Ports:
//   clk, rst_n                  rising-edge clock, async active-low reset
//   data_in[WIDTH], sel[2]      word to route and its destination channel
//   in_valid / in_ready         source handshake (in_ready depends on sel only)
//   data_out1..data_out4        head entry of each channel FIFO
//   out_valid[4] / out_ready[4] per-channel consumer handshake
//   accept_count[8]             total words accepted, modulo 256
module demux5bit_router #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out1,
  output logic [WIDTH-1:0] data_out2,
  output logic [WIDTH-1:0] data_out3,
  output logic [WIDTH-1:0] data_out4,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [7:0]       accept_count
);

  localparam int unsigned NCH = 4;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem    [NCH][DEPTH];
  logic [PW-1:0]    rd_ptr [NCH];
  logic [PW-1:0]    wr_ptr [NCH];
  logic [CW-1:0]    cnt    [NCH];

  logic             push;
  logic [NCH-1:0]   push_ch;
  logic [NCH-1:0]   pop;

  // Full check for the currently selected channel; registered state only.
  assign in_ready = (cnt[sel] != CW'(DEPTH));
  assign push     = in_valid & in_ready;

  // Per-channel push/pop strobes and non-empty flags.
  always_comb begin
    push_ch   = '0;
    pop       = '0;
    out_valid = '0;
    if (push) begin
      push_ch[sel] = 1'b1;
    end
    for (int c = 0; c < NCH; c++) begin
      out_valid[c] = (cnt[c] != '0);
      pop[c]       = out_valid[c] & out_ready[c];
    end
  end

  // Head entries come straight from storage; storage resets to zero so the
  // stale value seen while empty is never X.
  assign data_out1 = mem[0][rd_ptr[0]];
  assign data_out2 = mem[1][rd_ptr[1]];
  assign data_out3 = mem[2][rd_ptr[2]];
  assign data_out4 = mem[3][rd_ptr[3]];

  // Channel FIFO state: storage, pointers (wrap naturally, DEPTH is 2^PW), counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        cnt[c]    <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          mem[c][e] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (push_ch[c]) begin
          mem[c][wr_ptr[c]] <= data_in;
          wr_ptr[c]         <= wr_ptr[c] + PW'(1);
        end
        if (pop[c]) begin
          rd_ptr[c] <= rd_ptr[c] + PW'(1);
        end
        case ({push_ch[c], pop[c]})
          2'b10:   cnt[c] <= cnt[c] + CW'(1);
          2'b01:   cnt[c] <= cnt[c] - CW'(1);
          default: cnt[c] <= cnt[c];
        endcase
      end
    end
  end

  // Accepted-word tally, wraps modulo 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_count <= '0;
    end else if (push) begin
      accept_count <= accept_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux5bit_router.sv
// Directed self-checking bench for demux5bit_router.
module tb_demux5bit_router;

  logic       clk;
  logic       rst_n;
  logic [4:0] data_in;
  logic [1:0] sel;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] data_out1;
  logic [4:0] data_out2;
  logic [4:0] data_out3;
  logic [4:0] data_out4;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] accept_count;

  int checks;
  int failures;

  demux5bit_router #(.WIDTH(5), .DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .sel          (sel),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_out1    (data_out1),
    .data_out2    (data_out2),
    .data_out3    (data_out3),
    .data_out4    (data_out4),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .accept_count (accept_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [4:0] d);
    sel      = s;
    data_in  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Mid-cycle asynchronous reset pulse, released mid-cycle.
  task automatic reset_pulse();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    data_in   = '0;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = '0;
    #12;
    rst_n = 1'b1;
    #1;

    // Dirty the state, then reset asynchronously with no clock edge.
    push(2'd0, 5'h15);
    push(2'd1, 5'h16);
    chk("pre_reset_valid", 32'(out_valid), 32'h3);
    reset_pulse();
    sel = 2'd0;
    #0;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_accept_count", 32'(accept_count), 32'h0);
    chk("rst_data_out1", 32'(data_out1), 32'h0);
    chk("rst_data_out2", 32'(data_out2), 32'h0);
    chk("rst_data_out34", 32'({data_out3, data_out4}), 32'h0);
    release_reset();

    // Basic routing on consecutive edges.
    push(2'd0, 5'h11);
    push(2'd1, 5'h12);
    push(2'd2, 5'h13);
    push(2'd3, 5'h14);
    chk("route_data_out1", 32'(data_out1), 32'h11);
    chk("route_data_out2", 32'(data_out2), 32'h12);
    chk("route_data_out3", 32'(data_out3), 32'h13);
    chk("route_data_out4", 32'(data_out4), 32'h14);
    chk("route_out_valid", 32'(out_valid), 32'hF);
    chk("route_accept_count", 32'(accept_count), 32'd4);
    out_ready = 4'hF;
    step();
    out_ready = 4'h0;
    chk("route_drained", 32'(out_valid), 32'h0);

    // Fill ch2, backpressure, then wrap.
    push(2'd1, 5'h0A);
    push(2'd1, 5'h0B);
    chk("fill_data_out2", 32'(data_out2), 32'h0A);
    sel      = 2'd1;
    data_in  = 5'h0C;
    in_valid = 1'b1;
    #0;
    chk("full_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("full_not_accepted", 32'(accept_count), 32'd6);
    chk("full_head_stable", 32'(data_out2), 32'h0A);
    out_ready = 4'b0010;
    #0;
    chk("full_in_ready_with_pop", 32'(in_ready), 32'h0);
    step();
    out_ready = 4'b0000;
    chk("pop1_data_out2", 32'(data_out2), 32'h0B);
    chk("after_pop_in_ready", 32'(in_ready), 32'h1);
    chk("after_pop_accept_count", 32'(accept_count), 32'd6);
    step();
    in_valid = 1'b0;
    chk("wrap_push_accept_count", 32'(accept_count), 32'd7);
    chk("wrap_head_still_0b", 32'(data_out2), 32'h0B);
    out_ready = 4'b0010;
    step();
    chk("pop2_data_out2", 32'(data_out2), 32'h0C);
    chk("pop2_out_valid", 32'(out_valid), 32'b0010);
    step();
    out_ready = 4'b0000;
    chk("ch2_empty", 32'(out_valid), 32'h0);

    // Head-of-line isolation: full ch1 does not block ch4.
    push(2'd0, 5'h01);
    push(2'd0, 5'h02);
    sel = 2'd0;
    #0;
    chk("hol_ch1_full", 32'(in_ready), 32'h0);
    sel      = 2'd3;
    data_in  = 5'h1F;
    in_valid = 1'b1;
    #0;
    chk("hol_ch4_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("hol_data_out4", 32'(data_out4), 32'h1F);
    chk("hol_out_valid", 32'(out_valid), 32'b1001);
    chk("hol_accept_count", 32'(accept_count), 32'd10);
    chk("hol_data_out1", 32'(data_out1), 32'h01);
    out_ready = 4'hF;
    step();
    chk("hol_drain1_data_out1", 32'(data_out1), 32'h02);
    step();
    out_ready = 4'h0;
    chk("hol_drained", 32'(out_valid), 32'h0);

    // Simultaneous push and pop on ch3.
    push(2'd2, 5'h03);
    chk("sim_pre_data_out3", 32'(data_out3), 32'h03);
    sel       = 2'd2;
    data_in   = 5'h07;
    in_valid  = 1'b1;
    out_ready = 4'b0100;
    step();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    chk("sim_data_out3", 32'(data_out3), 32'h07);
    chk("sim_cnt_one", 32'(out_valid), 32'b0100);
    chk("sim_accept_count", 32'(accept_count), 32'd12);
    step();
    chk("sim_stable", 32'(data_out3), 32'h07);

    // Empty channel: push with out_ready high does not pop the new word.
    out_ready = 4'b0100;
    step();
    chk("empty_ch3", 32'(out_valid), 32'h0);
    push(2'd2, 5'h09);
    chk("empty_push_kept", 32'(out_valid), 32'b0100);
    chk("empty_push_data", 32'(data_out3), 32'h09);
    step();
    out_ready = 4'b0000;
    chk("empty_push_popped", 32'(out_valid), 32'h0);

    // Counter wrap from a fresh reset: 257 pushes, all consumers ready.
    reset_pulse();
    release_reset();
    out_ready = 4'hF;
    for (int i = 0; i < 257; i++) begin
      push(2'(i % 4), 5'(i));
      if (i == 254) chk("cnt_255", 32'(accept_count), 32'd255);
      if (i == 255) chk("cnt_wrap_0", 32'(accept_count), 32'd0);
    end
    chk("cnt_257", 32'(accept_count), 32'd1);
    step();
    step();
    chk("wrap_drained", 32'(out_valid), 32'h0);
    out_ready = 4'h0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
